tri_array_decoder: RTL and testbench
====================================

// Module: tri_array_decoder
// PURPOSE
//  Reader side of the group-triangular register array: a writer flop-array packs row a, column b (b<a)
//  as in[a] when a/M==b/M, else ~in[a+1]. This block takes one packed W-bit word (rows 0..W/N-1, row a =
//  bits [a*N +: N]) and scans it one row per cycle. It reconstructs the source bits, marks which are
//  recoverable, and flags any inconsistency. Used by cosim benches and as a self-check behind the array.
// PARAMETERS
//  N      16    row width / column count of the array
//  M      5     group size; row/column a belongs to group a/M
//  W      128   packed word width; ROWS = W/N rows scanned (must divide evenly)
// PORTS
//  clk        in   1      single clock, rising edge
//  rst        in   1      synchronous, active-high reset
//  in_valid   in   1      packed word offered
//  in_ready   out  1      block can accept a word (IDLE only)
//  in_data    in   W      packed triangular word
//  out_valid  out  1      decode result available
//  out_ready  in   1      consumer takes result
//  out_bits   out  ROWS+1 recovered source bits in[0..ROWS]; 0 where unknown
//  out_known  out  ROWS+1 1 = corresponding out_bits is determined by the word
//  out_err    out  1      word is not a legal encoding of any source vector
// BEHAVIOUR
//  - Reset (rst=1 at posedge): state IDLE, row counter 0, in_ready=1, out_valid=0, out_bits=0,
//    out_known=0, out_err=0. Reset in any state, mid-scan included, aborts and discards the word.
//  - FSM: IDLE -(in_valid&&in_ready)-> SCAN; SCAN -(row==ROWS-1)-> DONE; DONE -(out_ready)-> IDLE.
//  - Accept: word latched at the handshake edge; in_ready=0 in SCAN and DONE (no pipelining, no skid).
//  - SCAN: one row per cycle, row 0 first. Word accepted at edge t -> out_valid=1 after edge t+ROWS.
//  - Row a classification (columns b<a only; columns b>=a are don't-care and never affect outputs):
//      same-group bits (b/M==a/M): must all be equal; value v -> claims in[a]=v.
//      cross-group bits (b/M!=a/M): must all be equal; value u -> claims in[a+1]=~u.
//      row with no bits of a class makes no claim for that class (e.g. row 0; rows a%M==0 same-group).
//  - Claim merge: first claim on index k sets out_bits[k] and out_known[k]. A later claim on an already
//    known k with a different value sets err. Intra-row disagreement also sets err. err is sticky to DONE.
//  - DONE: out_valid=1 and outputs stable until out_ready; out_valid may not drop without out_ready.
//  - Handshake out_valid&&out_ready: out_valid=0, return to IDLE, in_ready=1 next cycle. Accumulators
//    clear on the next accept, not on the return to IDLE; outputs are valid only while out_valid=1.
//  - Simultaneous in_valid with DONE handshake: not accepted that cycle (in_ready still 0).
//  - Unknown indices (out_known=0) report out_bits=0; never X.
// STRUCTURE
//  - Shared package tri_array_pkg: localparams N, M, W, ROWS; typedef enum {IDLE,SCAN,DONE} state;
//    typedef for the row slice logic [N-1:0].
//  - Sub-module tri_row_check (combinational): inputs row index + N-bit row; outputs same_has, same_val,
//    same_bad, cross_has, cross_val, cross_bad. Top holds FSM, row counter, word register, accumulators.
// TESTING (bench carries a behavioural encoder for the writer rule above)
//  1 encode src=0, clean word -> after ROWS+1 cycles out_bits=9'h000, out_known=9'h1DE, out_err=0.
//  2 encode src=9'h1FF, all upper-triangle bits randomised -> out_bits=9'h1DE, out_known=9'h1DE,
//    out_err=0 (upper-triangle bits ignored).
//  3 clean word from src=0, flip row 3 col 0 -> out_err=1 (intra-row same-group mismatch).
//  4 clean word from src=0, set row 5 cols 0..4 to 0 (claims in[6]=1 vs row 6 claim 0) -> out_err=1.
//  5 hold out_ready=0 for 10 cycles in DONE -> out_valid and outputs stable, in_ready=0 throughout;
//    then out_ready=1 -> in_ready=1 next cycle and a back-to-back word is accepted.
//  6 assert rst at SCAN row 3 -> next cycle IDLE, in_ready=1, out_valid=0; fresh word decodes correctly.

Source files
------------

// File: rtl/tri_array_decoder_pkg.sv
// Shared parameters and types for the group-triangular array reader.
// Geometry: N columns per row, groups of M rows/columns, ROWS rows packed in W bits.
// No state here; types only.
package tri_array_pkg;

  localparam int N    = 16;
  localparam int M    = 5;
  localparam int W    = 128;
  localparam int ROWS = W / N;
  localparam int RW   = $clog2(ROWS);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  typedef logic [N-1:0]    row_t;
  typedef logic [RW-1:0]   row_idx_t;
  typedef logic [ROWS:0]   src_t;

endpackage

// File: rtl/tri_array_decoder_row_check.sv
// Classifies one packed row: same-group columns and cross-group columns below the diagonal.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of row index and row bits.
module tri_row_check
  import tri_array_pkg::*;
(
  input  row_idx_t row_idx,
  input  row_t     row,
  output logic     same_has,
  output logic     same_val,
  output logic     same_bad,
  output logic     cross_has,
  output logic     cross_val,   // raw stored bit; the claimed source bit is its inverse
  output logic     cross_bad
);

  // Scan columns b < row_idx; first bit of each class sets the reference value,
  // any later bit of that class that differs marks the class inconsistent.
  always_comb begin
    same_has  = 1'b0;
    same_val  = 1'b0;
    same_bad  = 1'b0;
    cross_has = 1'b0;
    cross_val = 1'b0;
    cross_bad = 1'b0;
    for (int b = 0; b < N; b++) begin
      if (b < int'(row_idx)) begin
        if ((b / M) == (int'(row_idx) / M)) begin
          if (!same_has) begin
            same_has = 1'b1;
            same_val = row[b];
          end else if (row[b] != same_val) begin
            same_bad = 1'b1;
          end
        end else begin
          if (!cross_has) begin
            cross_has = 1'b1;
            cross_val = row[b];
          end else if (row[b] != cross_val) begin
            cross_bad = 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/tri_array_decoder.sv
// Decodes one packed triangular word into source bits, known mask and error flag.
// Latency: word accepted at edge t gives out_valid after edge t+ROWS (one row per cycle).
// Backpressure: single word in flight; in_ready only in IDLE, result held in DONE until out_ready.
module tri_array_decoder
  import tri_array_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [ROWS:0] out_bits,
  output logic [ROWS:0] out_known,
  output logic          out_err
);

  state_t         state_q, state_d;
  row_idx_t       row_q, row_d;
  logic [W-1:0]   word_q, word_d;
  src_t           bits_q, bits_d;
  src_t           known_q, known_d;
  logic           err_q, err_d;

  row_t           cur_row;
  logic [RW:0]    same_k;
  logic [RW:0]    cross_k;
  logic           same_has, same_val, same_bad;
  logic           cross_has, cross_val, cross_bad;

  assign cur_row = word_q[int'(row_q)*N +: N];
  // Same-group bits claim in[a]; cross-group bits claim in[a+1].
  assign same_k  = {1'b0, row_q};
  assign cross_k = same_k + 1'b1;

  tri_row_check u_row_check (
    .row_idx   (row_q),
    .row       (cur_row),
    .same_has  (same_has),
    .same_val  (same_val),
    .same_bad  (same_bad),
    .cross_has (cross_has),
    .cross_val (cross_val),
    .cross_bad (cross_bad)
  );

  // State and accumulator registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      row_q   <= '0;
      word_q  <= '0;
      bits_q  <= '0;
      known_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      word_q  <= word_d;
      bits_q  <= bits_d;
      known_q <= known_d;
      err_q   <= err_d;
    end
  end

  // Next-state: accept clears accumulators, SCAN merges one row's claims, DONE waits for consumer.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    word_d  = word_q;
    bits_d  = bits_q;
    known_d = known_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = SCAN;
          row_d   = '0;
          word_d  = in_data;
          bits_d  = '0;
          known_d = '0;
          err_d   = 1'b0;
        end
      end
      SCAN: begin
        if (same_bad || cross_bad) begin
          err_d = 1'b1;
        end
        // Same and cross claims always target different indices, so they cannot collide here.
        if (same_has) begin
          if (known_q[same_k]) begin
            if (bits_q[same_k] != same_val) err_d = 1'b1;
          end else begin
            known_d[same_k] = 1'b1;
            bits_d[same_k]  = same_val;
          end
        end
        if (cross_has) begin
          if (known_q[cross_k]) begin
            if (bits_q[cross_k] != ~cross_val) err_d = 1'b1;
          end else begin
            known_d[cross_k] = 1'b1;
            bits_d[cross_k]  = ~cross_val;
          end
        end
        if (row_q == row_idx_t'(ROWS-1)) begin
          state_d = DONE;
        end else begin
          row_d = row_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs straight from state and accumulators; unknown bits are never set, so they read 0.
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    out_bits  = bits_q;
    out_known = known_q;
    out_err   = err_q;
  end

endmodule

// File: tb/tb_tri_array_decoder.sv
module tb_tri_array_decoder;
  import tri_array_pkg::*;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          out_valid;
  logic          out_ready;
  logic [ROWS:0] out_bits;
  logic [ROWS:0] out_known;
  logic          out_err;

  localparam logic [ROWS:0] KMASK = 9'h1DE;

  typedef struct packed {
    logic [ROWS:0] bits;
    logic [ROWS:0] known;
    logic          err;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  tri_array_decoder dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_bits  (out_bits),
    .out_known (out_known),
    .out_err   (out_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    total++;
    bad++;
    $display("FAIL %s", nm);
  endtask

  // Writer rule: row a col b<a holds in[a] within a group, ~in[a+1] across groups.
  function automatic logic [W-1:0] encode(input src_t src, input bit rand_upper);
    logic [W-1:0] w;
    w = '0;
    if (rand_upper) for (int i = 0; i < W/32; i++) w[i*32 +: 32] = $urandom();
    for (int a = 0; a < ROWS; a++)
      for (int b = 0; b < a; b++)
        w[a*N+b] = ((a / M) == (b / M)) ? src[a] : ~src[a+1];
    return w;
  endfunction

  // Reader reference: every stored bit is a claim on some source index; the first claim in
  // scan order (row, then column) fixes the value, any disagreeing claim is an error.
  function automatic exp_t decode(input logic [W-1:0] w);
    exp_t e;
    int   k;
    logic v;
    e = '0;
    for (int a = 0; a < ROWS; a++)
      for (int b = 0; b < a; b++) begin
        if ((a / M) == (b / M)) begin k = a;     v = w[a*N+b];  end
        else                    begin k = a + 1; v = ~w[a*N+b]; end
        if (!e.known[k]) begin e.known[k] = 1'b1; e.bits[k] = v; end
        else if (e.bits[k] != v) e.err = 1'b1;
      end
    return e;
  endfunction

  // Monitor: latency check on the first valid cycle, scoreboard compare on each handshake.
  int acc_cyc = 0;
  bit seen    = 1'b0;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        seen = 1'b0;
      end else begin
        if (in_valid && in_ready) acc_cyc = cyc + 1;
        if (out_valid && !seen) begin
          seen = 1'b1;
          chk("latency", cyc, acc_cyc + ROWS);
        end
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            fail_now("unexpected_output");
          end else begin
            e = sb.pop_front();
            chk("out_bits", out_bits, e.bits);
            chk("out_known", out_known, e.known);
            chk("out_err", out_err, e.err);
          end
          seen = 1'b0;
        end
      end
    end
  end

  // All stimulus runs at posedge+1.
  task automatic send(input logic [W-1:0] w, input exp_t e, input bit push);
    int n = 0;
    while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
    if (!in_ready) begin fail_now("send_timeout"); return; end
    if (push) sb.push_back(e);
    in_valid = 1'b1;
    in_data  = w;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain(input bit rand_rdy);
    int n  = 0;
    bit hs = 1'b0;
    bit done = 1'b0;
    while (!done && n < 100) begin
      out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      hs = out_valid && out_ready;
      @(posedge clk); #1;
      if (hs) done = 1'b1;
      n++;
    end
    out_ready = 1'b0;
    if (!done) fail_now("drain_timeout");
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [W-1:0] w, w2;
    exp_t         e, e2;
    src_t         s;
    int           n, a, b;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_bits", out_bits, 0);
    chk("rst_out_known", out_known, 0);
    chk("rst_out_err", out_err, 0);
    rst = 1'b0;

    // Clean word from all-zero source
    send(encode('0, 1'b0), '{bits: '0, known: KMASK, err: 1'b0}, 1'b1);
    drain(1'b0);

    // All-ones source, upper triangle randomised
    send(encode('1, 1'b1), '{bits: KMASK, known: KMASK, err: 1'b0}, 1'b1);
    drain(1'b1);

    // Intra-row same-group mismatch
    w = encode('0, 1'b0);
    w[3*N+0] = ~w[3*N+0];
    e = decode(w); e.err = 1'b1;
    send(w, e, 1'b1);
    drain(1'b1);

    // Cross-row conflict on in[6]
    w = encode('0, 1'b1);
    w[5*N +: 5] = '0;
    e = decode(w); e.err = 1'b1;
    send(w, e, 1'b1);
    drain(1'b1);

    // Hold in DONE for 10 cycles, then back-to-back word on the release
    s = src_t'($urandom());
    w = encode(s, 1'b1);
    e = '{bits: s & KMASK, known: KMASK, err: 1'b0};
    send(w, e, 1'b1);
    n = 0;
    while (!out_valid && n < 50) begin @(posedge clk); #1; n++; end
    if (!out_valid) fail_now("done_timeout");
    for (int i = 0; i < 10; i++) begin
      chk("hold_out_valid", out_valid, 1);
      chk("hold_in_ready", in_ready, 0);
      chk("hold_out_bits", out_bits, e.bits);
      chk("hold_out_known", out_known, e.known);
      chk("hold_out_err", out_err, e.err);
      @(posedge clk); #1;
    end
    s  = src_t'($urandom());
    w2 = encode(s, 1'b1);
    e2 = '{bits: s & KMASK, known: KMASK, err: 1'b0};
    sb.push_back(e2);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = w2;
    chk("hs_in_ready", in_ready, 0);
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("post_hs_in_ready", in_ready, 1);
    chk("post_hs_out_valid", out_valid, 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("b2b_accepted", in_ready, 0);
    drain(1'b1);

    // Reset in the middle of the scan discards the word
    w = encode(src_t'($urandom()), 1'b1);
    send(w, '0, 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_in_ready", in_ready, 1);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_out_err", out_err, 0);
    s = src_t'($urandom());
    send(encode(s, 1'b1), '{bits: s & KMASK, known: KMASK, err: 1'b0}, 1'b1);
    drain(1'b1);

    // Random sources, half of them with one lower-triangle bit corrupted
    for (int i = 0; i < 40; i++) begin
      s = src_t'($urandom());
      w = encode(s, 1'b1);
      if ($urandom_range(0, 1) == 1) begin
        a = $urandom_range(1, ROWS-1);
        b = $urandom_range(0, a-1);
        w[a*N+b] = ~w[a*N+b];
        e = decode(w);
      end else begin
        e = '{bits: s & KMASK, known: KMASK, err: 1'b0};
      end
      send(w, e, 1'b1);
      drain(1'b1);
    end

    repeat (3) @(posedge clk);
    if (sb.size() != 0) fail_now("scoreboard_not_empty");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
